// File: rtl/tank_pkg.sv
// Shared definitions for the tank game blocks.
//   dir_t            : tank / bullet heading (0=up, 1=right, 2=down, 3=left)
//   bullet_state_t   : bullet controller state encoding
//   bullet_dbg_t     : state and position snapshot exposed for observation
//   map / screen bound constants and the spawn-offset helper.
package tank_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FLY     = 2'd1,
    ST_EXPLODE = 2'd2
  } bullet_state_t;

  typedef struct packed {
    bullet_state_t state;
    logic [9:0]    bx;
    logic [9:0]    by;
    dir_t          dir;
  } bullet_dbg_t;

  // Playfield bounds of the map area and the visible screen.
  localparam int MAP_MIN      = 32;
  localparam int MAP_MAX      = 447;
  localparam int SCREEN_X_MAX = 639;
  localparam int SCREEN_Y_MAX = 479;

  // The bullet spawns near the middle of the 32x32 tank sprite.
  localparam int TANK_CENTER_OFS = 14;

  // Spawn coordinate: 11-bit sum, truncated back to the 10-bit position.
  function automatic logic [9:0] spawn_pos(input logic [9:0] p);
    logic [10:0] s;
    s = {1'b0, p} + 11'(TANK_CENTER_OFS);
    return s[9:0];
  endfunction

endpackage

// File: rtl/pos_edge_detect.sv
// Rising-edge detector with a registered history bit.
//   clk_i   : clock
//   reset_i : synchronous active-high reset (history cleared to 0)
//   sig_i   : level input
//   edge_o  : high for the cycle in which sig_i is 1 and was 0 last cycle
module pos_edge_detect (
  input  logic clk_i,
  input  logic reset_i,
  input  logic sig_i,
  output logic edge_o
);

  logic prev;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      prev <= 1'b0;
    end else begin
      prev <= sig_i;
    end
  end

  assign edge_o = sig_i & ~prev;

endmodule

// File: rtl/bullet_ctrl.sv
// Bullet controller: spawns one bullet from the tank on a fire press, moves
// it once per frame, draws it during the scan, requests brick destruction
// under its footprint and runs a timed explosion after hitting something.
//   clk_i, reset_i          : pixel clock, synchronous active-high reset
//   hpos_i, vpos_i          : current scan column / row
//   display_enable_i        : visible-area flag
//   frame_start_i           : one pulse per frame, outside the visible area
//   fire_i                  : fire button level
//   tank_x_i, tank_y_i      : tank top-left corner
//   tank_dir_i              : tank heading (dir_t encoding)
//   all_hard_block_i        : current pixel blocks the bullet
//   destroyable_block_i     : current pixel is a live brick corner
//   bullet_collide_o        : destroy request for the current pixel
//   bullet_on_o             : current pixel lies inside the flying bullet
//   explode_o               : explosion in progress
//   bullet_active_o         : controller not idle
//   dbg_o                   : state / position snapshot
//
// Handshake note: there is no valid/ready pair here; frame_start_i acts as the
// single advance strobe for both motion and the explosion timer, and fire is
// accepted only as a rising edge while idle.
module bullet_ctrl
  import tank_pkg::*;
#(
  parameter int SPEED          = 4,
  parameter int BULLET_SIZE    = 4,
  parameter int EXPLODE_FRAMES = 8
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [9:0]  hpos_i,
  input  logic [9:0]  vpos_i,
  input  logic        display_enable_i,
  input  logic        frame_start_i,
  input  logic        fire_i,
  input  logic [9:0]  tank_x_i,
  input  logic [9:0]  tank_y_i,
  input  logic [1:0]  tank_dir_i,
  input  logic        all_hard_block_i,
  input  logic        destroyable_block_i,
  output logic        bullet_collide_o,
  output logic        bullet_on_o,
  output logic        explode_o,
  output logic        bullet_active_o,
  output bullet_dbg_t dbg_o
);

  localparam int CNT_W = (EXPLODE_FRAMES > 1) ? $clog2(EXPLODE_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(EXPLODE_FRAMES - 1);
  localparam logic [10:0] STEP_W  = 11'(SPEED);
  localparam logic [10:0] SIZE_W  = 11'(BULLET_SIZE);
  localparam logic [10:0] X_LIMIT = 11'(SCREEN_X_MAX - BULLET_SIZE);
  localparam logic [10:0] Y_LIMIT = 11'(SCREEN_Y_MAX - BULLET_SIZE);

  bullet_state_t  state, next_state;
  logic [9:0]     bx, by;
  dir_t           dir;
  logic           hit_r;
  logic [CNT_W-1:0] expl_cnt;
  logic           fire_edge;

  pos_edge_detect u_fire_edge (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .sig_i   (fire_i),
    .edge_o  (fire_edge)
  );

  // Candidate next position. The extra MSB flags underflow when moving
  // up/left past zero; overshoot right/down is caught by the limit compare.
  logic [10:0] bx_ext, by_ext, nx, ny;
  logic        move_out;

  assign bx_ext = {1'b0, bx};
  assign by_ext = {1'b0, by};

  always_comb begin
    nx = bx_ext;
    ny = by_ext;
    case (dir)
      DIR_UP:    ny = by_ext - STEP_W;
      DIR_RIGHT: nx = bx_ext + STEP_W;
      DIR_DOWN:  ny = by_ext + STEP_W;
      DIR_LEFT:  nx = bx_ext - STEP_W;
      default:   ;
    endcase
  end

  assign move_out = nx[10] || ny[10] || (nx > X_LIMIT) || (ny > Y_LIMIT);

  // Footprint test against the live scan position (no pipeline delay).
  logic [10:0] h_ext, v_ext;
  logic        in_box;

  assign h_ext  = {1'b0, hpos_i};
  assign v_ext  = {1'b0, vpos_i};
  assign in_box = (h_ext >= bx_ext) && (h_ext < bx_ext + SIZE_W) &&
                  (v_ext >= by_ext) && (v_ext < by_ext + SIZE_W);

  // State register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (fire_edge) next_state = ST_FLY;
      end
      ST_FLY: begin
        if (frame_start_i) begin
          if (hit_r)         next_state = ST_EXPLODE;
          else if (move_out) next_state = ST_IDLE;
        end
      end
      ST_EXPLODE: begin
        if (frame_start_i && (expl_cnt == '0)) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Outputs.
  always_comb begin
    bullet_on_o      = (state == ST_FLY) && display_enable_i && in_box;
    bullet_collide_o = bullet_on_o && destroyable_block_i;
    explode_o        = (state == ST_EXPLODE);
    bullet_active_o  = (state != ST_IDLE);
  end

  // Bullet datapath: position, heading, hit flag and explosion timer.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      bx       <= '0;
      by       <= '0;
      dir      <= DIR_UP;
      hit_r    <= 1'b0;
      expl_cnt <= '0;
    end else begin
      // A spawn coinciding with frame_start stays put for that frame, since
      // motion only applies while already flying.
      if (state == ST_IDLE && fire_edge) begin
        bx  <= spawn_pos(tank_x_i);
        by  <= spawn_pos(tank_y_i);
        dir <= dir_t'(tank_dir_i);
      end else if (state == ST_FLY && frame_start_i && !hit_r && !move_out) begin
        bx <= nx[9:0];
        by <= ny[9:0];
      end

      // Hits accumulate over the visible scan and are consumed at the
      // following frame_start.
      if (state != ST_FLY || frame_start_i) begin
        hit_r <= 1'b0;
      end else if (bullet_on_o && all_hard_block_i) begin
        hit_r <= 1'b1;
      end

      if (state == ST_FLY && frame_start_i && hit_r) begin
        expl_cnt <= CNT_LOAD;
      end else if (state == ST_EXPLODE && frame_start_i && expl_cnt != '0) begin
        expl_cnt <= expl_cnt - 1'b1;
      end
    end
  end

  assign dbg_o = '{state: state, bx: bx, by: by, dir: dir};

endmodule

// File: tb/tb_bullet_ctrl.sv
// Testbench for bullet_ctrl: directed stimulus with hand-computed expected
// snapshots pushed to a queue and compared by an independent monitor.
module tb_bullet_ctrl;
  import tank_pkg::*;

  localparam int W = 26;

  // Clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic [9:0]  hpos = '0, vpos = '0;
  logic        de = 1'b0, frame_start = 1'b0, fire = 1'b0;
  logic [9:0]  tank_x = '0, tank_y = '0;
  logic [1:0]  tank_dir = '0;
  logic        hard = 1'b0, destr = 1'b0;
  logic        collide, on, explode, active;
  bullet_dbg_t dbg;

  bullet_ctrl #(.SPEED(4), .BULLET_SIZE(4), .EXPLODE_FRAMES(8)) dut (
    .clk_i               (clk),
    .reset_i             (reset),
    .hpos_i              (hpos),
    .vpos_i              (vpos),
    .display_enable_i    (de),
    .frame_start_i       (frame_start),
    .fire_i              (fire),
    .tank_x_i            (tank_x),
    .tank_y_i            (tank_y),
    .tank_dir_i          (tank_dir),
    .all_hard_block_i    (hard),
    .destroyable_block_i (destr),
    .bullet_collide_o    (collide),
    .bullet_on_o         (on),
    .explode_o           (explode),
    .bullet_active_o     (active),
    .dbg_o               (dbg)
  );

  // Observation vector: {state, bx, by, on, collide, explode, active}
  logic [W-1:0] obs;
  assign obs = {dbg.state, dbg.bx, dbg.by, on, collide, explode, active};

  localparam logic [W-1:0] M_ALL   = '1;
  localparam logic [W-1:0] M_NOPOS = {2'b11, 10'd0, 10'd0, 4'hF};

  function automatic logic [W-1:0] pk(input logic [1:0] st, input int x, input int y,
                                      input logic o, input logic c, input logic e,
                                      input logic a);
    return {st, 10'(x), 10'(y), o, c, e, a};
  endfunction

  // Scoreboard
  logic [W-1:0] exp_q[$];
  logic [W-1:0] msk_q[$];
  string        tag_q[$];
  int           n_checks = 0;
  int           n_fail = 0;

  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      logic [W-1:0] e, m;
      string t;
      e = exp_q.pop_front();
      m = msk_q.pop_front();
      t = tag_q.pop_front();
      n_checks++;
      if (((obs ^ e) & m) != '0) begin
        n_fail++;
        $display("FAIL %s: actual %h required %h (mask %h)", t, obs, e, m);
      end
    end
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_obs(input string t, input logic [W-1:0] e, input logic [W-1:0] m);
    exp_q.push_back(e);
    msk_q.push_back(m);
    tag_q.push_back(t);
  endtask

  task automatic clear_scan();
    de = 1'b0; hpos = '0; vpos = '0; hard = 1'b0; destr = 1'b0;
  endtask

  task automatic do_reset();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic frame();
    step();
    clear_scan();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame();
  endtask

  task automatic fire_press(input int x, input int y, input int d);
    step();
    tank_x = 10'(x); tank_y = 10'(y); tank_dir = 2'(d);
    fire = 1'b1;
    step();
    fire = 1'b0;
  endtask

  task automatic scan(input int h, input int v, input logic en, input logic hb, input logic db);
    step();
    hpos = 10'(h); vpos = 10'(v); de = en; hard = hb; destr = db;
  endtask

  initial begin
    // Reset state
    repeat (3) step();
    reset = 1'b0;
    expect_obs("reset_state", pk(ST_IDLE, 0, 0, 0, 0, 0, 0), M_ALL);

    // Spawn and travel right
    fire_press(100, 200, 1);
    expect_obs("spawn_right", pk(ST_FLY, 114, 214, 0, 0, 0, 1), M_ALL);
    frames(3);
    expect_obs("move_3_frames", pk(ST_FLY, 126, 214, 0, 0, 0, 1), M_ALL);

    // Footprint boundaries (bullet covers x 126..129, y 214..217)
    scan(126, 214, 1, 0, 0); expect_obs("on_top_left",  pk(ST_FLY, 126, 214, 1, 0, 0, 1), M_ALL);
    scan(130, 214, 1, 0, 0); expect_obs("off_right",    pk(ST_FLY, 126, 214, 0, 0, 0, 1), M_ALL);
    scan(129, 217, 1, 0, 0); expect_obs("on_bot_right", pk(ST_FLY, 126, 214, 1, 0, 0, 1), M_ALL);
    scan(129, 218, 1, 0, 0); expect_obs("off_below",    pk(ST_FLY, 126, 214, 0, 0, 0, 1), M_ALL);
    scan(125, 215, 1, 0, 0); expect_obs("off_left",     pk(ST_FLY, 126, 214, 0, 0, 0, 1), M_ALL);
    scan(127, 215, 0, 0, 0); expect_obs("off_blanking", pk(ST_FLY, 126, 214, 0, 0, 0, 1), M_ALL);

    // Brick hit: collide only on overlapping pixels, then 8-frame explosion
    scan(131, 215, 1, 1, 1); expect_obs("brick_outside", pk(ST_FLY, 126, 214, 0, 0, 0, 1), M_ALL);
    scan(127, 215, 1, 1, 1); expect_obs("brick_collide", pk(ST_FLY, 126, 214, 1, 1, 0, 1), M_ALL);
    scan(128, 216, 1, 1, 1); expect_obs("brick_collide2", pk(ST_FLY, 126, 214, 1, 1, 0, 1), M_ALL);
    frame();
    expect_obs("explode_enter", pk(ST_EXPLODE, 126, 214, 0, 0, 1, 1), M_ALL);
    scan(127, 215, 1, 1, 1); expect_obs("no_draw_in_explode", pk(ST_EXPLODE, 126, 214, 0, 0, 1, 1), M_ALL);
    fire_press(10, 10, 2);
    expect_obs("fire_ignored_explode", pk(ST_EXPLODE, 126, 214, 0, 0, 1, 1), M_ALL);
    for (int k = 1; k < 8; k++) begin
      frame();
      expect_obs($sformatf("explode_frame_%0d", k), pk(ST_EXPLODE, 0, 0, 0, 0, 1, 1), M_NOPOS);
    end
    frame();
    expect_obs("explode_done", pk(ST_IDLE, 0, 0, 0, 0, 0, 0), M_NOPOS);

    // Wall hit: no collide, explosion next frame, then reset mid-explosion
    fire_press(300, 100, 2);
    expect_obs("spawn_down", pk(ST_FLY, 314, 114, 0, 0, 0, 1), M_ALL);
    frame();
    expect_obs("move_down", pk(ST_FLY, 314, 118, 0, 0, 0, 1), M_ALL);
    scan(315, 119, 1, 1, 0); expect_obs("wall_no_collide", pk(ST_FLY, 314, 118, 1, 0, 0, 1), M_ALL);
    frame();
    expect_obs("wall_explode", pk(ST_EXPLODE, 314, 118, 0, 0, 1, 1), M_ALL);
    do_reset();
    expect_obs("reset_mid_explode", pk(ST_IDLE, 0, 0, 0, 0, 0, 0), M_ALL);

    // Top edge: by=2 moving up exits instead of wrapping
    fire_press(50, 0, 0);
    expect_obs("spawn_up", pk(ST_FLY, 64, 14, 0, 0, 0, 1), M_ALL);
    frames(3);
    expect_obs("up_by2", pk(ST_FLY, 64, 2, 0, 0, 0, 1), M_ALL);
    frame();
    expect_obs("up_exit", pk(ST_IDLE, 64, 2, 0, 0, 0, 0), M_ALL);

    // Right edge: 634 is last legal x (limit 635)
    fire_press(600, 50, 1);
    frames(5);
    expect_obs("right_last", pk(ST_FLY, 634, 64, 0, 0, 0, 1), M_ALL);
    frame();
    expect_obs("right_exit", pk(ST_IDLE, 634, 64, 0, 0, 0, 0), M_ALL);

    // Bottom edge: 474 is last legal y (limit 475)
    fire_press(200, 440, 2);
    frames(5);
    expect_obs("down_last", pk(ST_FLY, 214, 474, 0, 0, 0, 1), M_ALL);
    frame();
    expect_obs("down_exit", pk(ST_IDLE, 214, 474, 0, 0, 0, 0), M_ALL);

    // Left edge
    fire_press(0, 300, 3);
    frames(3);
    expect_obs("left_bx2", pk(ST_FLY, 2, 314, 0, 0, 0, 1), M_ALL);
    frame();
    expect_obs("left_exit", pk(ST_IDLE, 2, 314, 0, 0, 0, 0), M_ALL);

    // Fire coinciding with frame_start in IDLE: spawn without moving
    step();
    tank_x = 10'd200; tank_y = 10'd150; tank_dir = 2'd1;
    fire = 1'b1; frame_start = 1'b1;
    step();
    fire = 1'b0; frame_start = 1'b0;
    expect_obs("spawn_on_frame", pk(ST_FLY, 214, 164, 0, 0, 0, 1), M_ALL);
    frame();
    expect_obs("spawn_then_move", pk(ST_FLY, 218, 164, 0, 0, 0, 1), M_ALL);

    // Fire held for 100 frames plus a second press: single spawn
    do_reset();
    step();
    tank_x = 10'd100; tank_y = 10'd200; tank_dir = 2'd1;
    fire = 1'b1;
    step();
    expect_obs("held_spawn", pk(ST_FLY, 114, 214, 0, 0, 0, 1), M_ALL);
    tank_x = 10'd10; tank_y = 10'd10;
    frames(100);
    expect_obs("held_100_frames", pk(ST_FLY, 514, 214, 0, 0, 0, 1), M_ALL);
    step(); fire = 1'b0;
    step(); fire = 1'b1;
    step(); fire = 1'b0;
    expect_obs("second_press_ignored", pk(ST_FLY, 514, 214, 0, 0, 0, 1), M_ALL);

    // Reset while colliding
    scan(515, 215, 1, 0, 1);
    expect_obs("collide_before_reset", pk(ST_FLY, 514, 214, 1, 1, 0, 1), M_ALL);
    step();
    reset = 1'b1;
    step();
    expect_obs("reset_during_collide", pk(ST_IDLE, 0, 0, 0, 0, 0, 0), M_ALL);
    reset = 1'b0;
    clear_scan();

    // Drain scoreboard with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d entries left, required 0", exp_q.size());
    end
    @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bullet_ctrl.md
BULLET_CTRL -- requirements
Module: bullet_ctrl

Interface
REQ-001 The module SHALL have parameter SPEED, default 4, giving bullet travel in pixels per frame.
REQ-002 The module SHALL have parameter BULLET_SIZE, default 4, giving the bullet square edge in pixels.
REQ-003 The module SHALL have parameter EXPLODE_FRAMES, default 8, giving the explosion duration in frames.
REQ-004 The module SHALL use one clock and a synchronous, active-high reset.
REQ-005 The module SHALL have port clk_i, input, 1 bit: the pixel clock.
REQ-006 The module SHALL have port reset_i, input, 1 bit: synchronous active-high reset.
REQ-007 The module SHALL have port hpos_i, input, 10 bits: current scan column.
REQ-008 The module SHALL have port vpos_i, input, 10 bits: current scan row.
REQ-009 The module SHALL have port display_enable_i, input, 1 bit: visible-area flag.
REQ-010 The module SHALL have port frame_start_i, input, 1 bit: one-cycle pulse per frame, issued outside the visible area.
REQ-011 The module SHALL have port fire_i, input, 1 bit: level-sensitive fire button.
REQ-012 The module SHALL have port tank_x_i, input, 10 bits: tank 32x32 top-left column.
REQ-013 The module SHALL have port tank_y_i, input, 10 bits: tank 32x32 top-left row.
REQ-014 The module SHALL have port tank_dir_i, input, 2 bits, encoded 0=up, 1=right, 2=down, 3=left.
REQ-015 The module SHALL have port all_hard_block_i, input, 1 bit: map flag for the current pixel; blocks the bullet.
REQ-016 The module SHALL have port destroyable_block_i, input, 1 bit: map flag for the current pixel; the pixel is a live brick corner.
REQ-017 The module SHALL have port bullet_collide_o, output, 1 bit: destroy request for the current pixel, fed to the map block's bullet_collide_i.
REQ-018 The module SHALL have port bullet_on_o, output, 1 bit: the current pixel lies inside the flying bullet.
REQ-019 The module SHALL have port explode_o, output, 1 bit: explosion in progress.
REQ-020 The module SHALL have port bullet_active_o, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-021 The module SHALL implement a state machine with states IDLE, FLY and EXPLODE.
REQ-022 A fire press SHALL be registered only on a rising edge of fire_i, through a registered edge detector.
REQ-023 In IDLE, a fire rising edge SHALL move the state to FLY on the next clock.
REQ-024 On that transition, the bullet SHALL load bx=tank_x_i+14, by=tank_y_i+14 and latch dir=tank_dir_i.
REQ-025 In FLY and EXPLODE, fire edges SHALL be ignored: one bullet at a time.
REQ-026 bullet_on_o SHALL equal (state==FLY) && display_enable_i && bx<=hpos_i<bx+BULLET_SIZE && by<=vpos_i<by+BULLET_SIZE.
REQ-027 bullet_on_o SHALL be combinational from registered state, with zero latency relative to hpos_i/vpos_i.
REQ-028 In FLY, hit_r SHALL set on any cycle where bullet_on_o && all_hard_block_i.
REQ-029 bullet_collide_o SHALL equal bullet_on_o && destroyable_block_i on the same cycle, so that every brick corner under the bullet footprint is cleared.
REQ-030 On frame_start_i in FLY with hit_r=1, the state SHALL go to EXPLODE, load expl_cnt=EXPLODE_FRAMES-1 and clear hit_r.
REQ-031 On frame_start_i in FLY with hit_r=0, the bullet SHALL move SPEED pixels in dir.
REQ-032 If that move would underflow below 0 or exceed 639-BULLET_SIZE (x) / 479-BULLET_SIZE (y), the state SHALL go to IDLE instead of moving.
REQ-033 All position arithmetic SHALL use 11-bit intermediates, with underflow detected from the extra bit.
REQ-034 In EXPLODE, each frame_start_i SHALL decrement expl_cnt; at expl_cnt==0 the state SHALL go to IDLE.
REQ-035 explode_o SHALL be high exactly while the state is EXPLODE.
REQ-036 If a fire edge and frame_start_i coincide in IDLE, the bullet SHALL spawn and SHALL NOT move in that frame.
REQ-037 hit_r SHALL be cleared on every frame_start_i and whenever the state is not FLY.

Reset
REQ-038 On reset_i, the state SHALL be IDLE, bx/by/dir/hit_r/expl_cnt SHALL be 0 and the edge-detector register SHALL be 0.
REQ-039 Reset SHALL apply mid-flight or mid-explosion with no residual collide pulse; all outputs SHALL be 0 on the cycle after reset.

Structure
REQ-040 The shared package tank_pkg SHALL hold the dir_t enum, the bullet state enum, and the map bounds constants 32/447 and 639/479.
REQ-041 Fire edge detection SHALL reuse the existing sub-module pos_edge_detect; no other sub-modules.

Verification
REQ-042 Tank (100,200), dir=1, fire pulse: bx=114, by=214, FLY; after 3 frame_starts, bx=126, by=214.
REQ-043 Bullet scan overlaps a brick pixel with destroyable=1: bullet_collide_o is high on exactly the overlapping pixels; at the next frame_start the state is EXPLODE and explode_o=1 for 8 frames, then IDLE.
REQ-044 Bullet hits a wall pixel (all_hard=1, destroyable=0): bullet_collide_o stays 0 and the state goes to EXPLODE at the next frame_start.
REQ-045 dir=0, by=2, no hit: the next frame_start goes to IDLE, with no wrap to by=1022.
REQ-046 fire held high for 100 frames, and a second press during FLY: only one spawn occurs.
REQ-047 reset_i asserted during FLY while bullet_collide_o=1: the next cycle has all outputs 0 and the state IDLE.
